spi_slave: RTL

//   SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first. Pairs with an external SPI master.

---
 rtl/spi_slave.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first. Pins are oversampled in the clk domain; local logic sees
// a one-word tx holding buffer and an rx register, both with valid/ready handshakes.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_busy,
    output logic              o_underrun,
    output logic              o_overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_n_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_n_d;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_tx_buf;
    logic                   r_tx_full;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic                   r_overrun;

    logic w_sclk_s, w_cs_n_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_load, w_shift, w_rx_bit, w_abort, w_word_done, w_tx_wr;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n_s = r_cs_n_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d;
    assign w_cs_rise   = w_cs_n_s & ~r_cs_n_d;

    // cs_n idles high so a reset never looks like a frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_cs_n_sync <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_n_d    <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_n_d    <= w_cs_n_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_rx_bit     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = S_ACTIVE;
                    w_load       = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_rx_bit = w_sclk_rise;
                    // A fall right after a completed word opens the next word slot.
                    if (w_sclk_fall) begin
                        if (r_bit_cnt != '0) begin
                            w_shift = 1'b1;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_word_done = w_rx_bit && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_tx_wr     = i_tx_valid & ~r_tx_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_abort) begin
                r_tx_shift <= '0;
            end else if (w_load) begin
                r_tx_shift <= r_tx_full ? r_tx_buf : '0;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end

            // A write is only accepted while empty, so it never collides with a load of a full buffer.
            if (w_tx_wr) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end
            r_underrun <= w_load & ~r_tx_full;

            if (w_abort) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_rx_bit) begin
                r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
            end

            if (w_word_done) begin
                r_rx_data  <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            r_overrun <= w_word_done & r_rx_valid & ~i_rx_ready;
        end
    end

    assign o_miso     = (r_state == S_ACTIVE) ? r_tx_shift[DATA_W-1] : 1'b0;
    assign o_tx_ready = ~r_tx_full;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = ~w_cs_n_s;
    assign o_underrun = r_underrun;
    assign o_overrun  = r_overrun;

endmodule
